// File: rtl/dpa_train_ctrl.sv
// Receive-side DPA training sequencer: sweeps the input-delay tap, qualifies each
// tap against the 10-cycle training period, centres on the widest passing window
// and reports the word-alignment offset of the recovered stream.
module dpa_train_ctrl #(
   parameter logic [19:0] PATTERN       = 20'b0000_0000_0011_1111_1111,
   parameter int unsigned TAP_W         = 5,
   parameter int unsigned NUM_TAPS      = 32,
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned CHECK_CYCLES  = 64,
   parameter int unsigned MIN_EYE       = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             pat_en,
   input  logic [1:0]       rx_data,
   output logic [TAP_W-1:0] tap_value,
   output logic             tap_load,
   output logic             busy,
   output logic             done,
   output logic             locked,
   output logic             fail,
   output logic [TAP_W-1:0] eye_start,
   output logic [TAP_W:0]   eye_width,
   output logic [3:0]       phase_ofs
);

   localparam int unsigned CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CHECK_CYCLES - 1);
   localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(NUM_TAPS - 1);
   localparam logic [TAP_W:0]   MIN_LEN     = (TAP_W+1)'(MIN_EYE);

   typedef enum logic [3:0] {
      StIdle, StLoad, StSettle, StCheck, StEval, StCenter, StAlignWait, StAlign, StFinish
   } state_t;

   state_t           state_q;
   logic [19:0]      hist_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc;
   logic [TAP_W-1:0] tap_q;
   logic             err_q;
   logic             trans_q;
   logic [TAP_W:0]   cur_len_q;
   logic [TAP_W-1:0] cur_start_q;
   logic [TAP_W:0]   best_len_q;
   logic [TAP_W-1:0] best_start_q;

   logic             tap_pass;
   logic [TAP_W:0]   run_len;
   logic [TAP_W-1:0] run_start;
   logic [TAP_W-1:0] center_tap;
   logic [19:0]      rot;
   logic             align_hit;
   logic [3:0]       align_k;

   // Shift history of received pairs; oldest pair sits in [19:18], ten cycles back.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= '0;
      end else begin
         hist_q <= {hist_q[17:0], rx_data};
      end
   end

   // Tap qualification, window tracking and centre/alignment helpers.
   always_comb begin
      cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      tap_pass   = ~err_q & trans_q;
      run_len    = cur_len_q + (TAP_W+1)'(1);
      run_start  = (cur_len_q == '0) ? tap_q : cur_start_q;
      center_tap = best_start_q + TAP_W'(best_len_q >> 1);
      rot        = '0;
      align_hit  = 1'b0;
      align_k    = '0;
      // Descending scan so the smallest matching rotation wins.
      for (int k = 9; k >= 0; k--) begin
         rot = (PATTERN << (2 * k)) | (PATTERN >> (20 - 2 * k));
         if (hist_q == rot) begin
            align_hit = 1'b1;
            align_k   = 4'(k);
         end
      end
   end

   // Training state machine with registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         tap_q        <= '0;
         err_q        <= 1'b0;
         trans_q      <= 1'b0;
         cur_len_q    <= '0;
         cur_start_q  <= '0;
         best_len_q   <= '0;
         best_start_q <= '0;
         pat_en       <= 1'b0;
         busy         <= 1'b0;
         tap_value    <= '0;
         tap_load     <= 1'b0;
         done         <= 1'b0;
         locked       <= 1'b0;
         fail         <= 1'b0;
         eye_start    <= '0;
         eye_width    <= '0;
         phase_ofs    <= '0;
      end else begin
         tap_load <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  done         <= 1'b0;
                  locked       <= 1'b0;
                  fail         <= 1'b0;
                  eye_start    <= '0;
                  eye_width    <= '0;
                  phase_ofs    <= '0;
                  tap_q        <= '0;
                  cnt_q        <= '0;
                  cur_len_q    <= '0;
                  cur_start_q  <= '0;
                  best_len_q   <= '0;
                  best_start_q <= '0;
                  busy         <= 1'b1;
                  pat_en       <= 1'b1;
                  state_q      <= StLoad;
               end
            end
            StLoad: begin
               tap_value <= tap_q;
               tap_load  <= 1'b1;
               cnt_q     <= '0;
               state_q   <= StSettle;
            end
            StSettle: begin
               if (cnt_q == SETTLE_LAST) begin
                  cnt_q   <= '0;
                  err_q   <= 1'b0;
                  trans_q <= 1'b0;
                  state_q <= StCheck;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            StCheck: begin
               if (rx_data != hist_q[19:18]) err_q <= 1'b1;
               if (rx_data != hist_q[1:0]) trans_q <= 1'b1;
               if (cnt_q == CHECK_LAST) begin
                  cnt_q   <= '0;
                  state_q <= StEval;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            StEval: begin
               if (tap_pass) begin
                  cur_len_q   <= run_len;
                  cur_start_q <= run_start;
                  // Strictly greater: the first of equal-width windows is kept.
                  if (run_len > best_len_q) begin
                     best_len_q   <= run_len;
                     best_start_q <= run_start;
                  end
               end else begin
                  cur_len_q <= '0;
               end
               if (tap_q == TAP_LAST) begin
                  state_q <= StCenter;
               end else begin
                  tap_q   <= tap_q + TAP_W'(1);
                  state_q <= StLoad;
               end
            end
            StCenter: begin
               eye_start <= best_start_q;
               eye_width <= best_len_q;
               tap_load  <= 1'b1;
               cnt_q     <= '0;
               if (best_len_q < MIN_LEN) begin
                  tap_value <= '0;
                  fail      <= 1'b1;
                  state_q   <= StFinish;
               end else begin
                  tap_value <= center_tap;
                  state_q   <= StAlignWait;
               end
            end
            StAlignWait: begin
               if (cnt_q == SETTLE_LAST) begin
                  cnt_q   <= '0;
                  state_q <= StAlign;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            StAlign: begin
               if (align_hit) begin
                  phase_ofs <= align_k;
                  locked    <= 1'b1;
               end else begin
                  phase_ofs <= '0;
                  fail      <= 1'b1;
               end
               state_q <= StFinish;
            end
            StFinish: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               pat_en  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_dpa_train_ctrl.sv
// Bench for dpa_train_ctrl: a loopback model feeds the training stream (or noise)
// depending on the currently loaded tap; expected results are queued at start and
// compared when done rises.
module tb_dpa_train_ctrl;

   localparam logic [19:0] PAT   = 20'b0000_0000_0011_1111_1111;
   localparam logic [19:0] OTHER = 20'b1010_0110_0011_1001_0110;
   localparam int          NT    = 32;
   localparam int          BUDGET = 3000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] rx_data = 2'b00;
   logic       pat_en, tap_load, busy, done, locked, fail;
   logic [4:0] tap_value, eye_start;
   logic [5:0] eye_width;
   logic [3:0] phase_ofs;

   dpa_train_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pat_en    (pat_en),
      .rx_data   (rx_data),
      .tap_value (tap_value),
      .tap_load  (tap_load),
      .busy      (busy),
      .done      (done),
      .locked    (locked),
      .fail      (fail),
      .eye_start (eye_start),
      .eye_width (eye_width),
      .phase_ofs (phase_ofs)
   );

   always #4 clk = ~clk;

   typedef struct {
      int es;
      int ew;
      int tap;
      int lk;
      int fl;
      int ph;
   } exp_t;

   exp_t        exp_q[$];
   int          n_vec = 0;
   int          n_mis = 0;

   // Loopback model state.
   logic [31:0] pass_mask = '0;
   logic [19:0] word = PAT;
   bit          stuck = 1'b0;
   int          kwant = 0;
   int          d = 0;
   int          cyc = 0;
   int          load_cnt = 0;
   logic [4:0]  cur_tap = '0;
   logic [4:0]  last_tap = '0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs != exp) begin
         n_mis++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] span(input int lo, input int hi);
      logic [31:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [1:0] next_pair();
      int idx;
      idx = (cyc + d) % 10;
      if (stuck) return 2'b10;
      if (pass_mask[cur_tap]) return word[19 - 2 * idx -: 2];
      return 2'($urandom_range(0, 3));
   endfunction

   // Stream driver: one pair per cycle, changed just after the rising edge.
   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         #1;
         rx_data = next_pair();
      end
   end

   // Tap monitor. After the centring load, re-phase the stream so that the
   // history seen at alignment (pairs from 6..15 cycles after the strobe)
   // equals ROTL20(word, 2*kwant).
   initial begin
      forever begin
         @(negedge clk);
         if (tap_load) begin
            load_cnt = load_cnt + 1;
            cur_tap  = tap_value;
            last_tap = tap_value;
            if (load_cnt == NT + 1) d = ((kwant - cyc - 6) % 10 + 10) % 10;
         end
      end
   end

   task automatic run_case(input string name, input logic [31:0] mask, input logic [19:0] w,
                           input bit stk, input int kw, input int es, input int ew,
                           input int tp, input int lk, input int fl, input int ph,
                           input bit poke);
      exp_t e;
      int   pk;
      pass_mask = mask;
      word      = w;
      stuck     = stk;
      kwant     = kw;
      e.es = es; e.ew = ew; e.tap = tp; e.lk = lk; e.fl = fl; e.ph = ph;
      exp_q.push_back(e);
      load_cnt = 0;
      pk = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({name, ".busy_run"}, busy, 1);
      chk({name, ".pat_en_run"}, pat_en, 1);
      for (int i = 0; i < BUDGET; i++) begin
         @(negedge clk);
         if (done) break;
         // Second start well inside the CHECK phase of tap 5.
         if (poke && load_cnt == 6) begin
            pk++;
            start = (pk == 30);
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk({name, ".done"}, done, 1);
      e = exp_q.pop_front();
      chk({name, ".eye_start"}, eye_start, e.es);
      chk({name, ".eye_width"}, eye_width, e.ew);
      chk({name, ".final_tap"}, last_tap, e.tap);
      chk({name, ".tap_value"}, tap_value, e.tap);
      chk({name, ".locked"}, locked, e.lk);
      chk({name, ".fail"}, fail, e.fl);
      chk({name, ".phase_ofs"}, phase_ofs, e.ph);
      chk({name, ".tap_loads"}, load_cnt, NT + 1);
      chk({name, ".busy_idle"}, busy, 0);
      repeat (5) @(negedge clk);
      chk({name, ".done_held"}, done, 1);
      chk({name, ".pat_en_idle"}, pat_en, 0);
   endtask

   initial begin
      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("reset.pat_en", pat_en, 0);
      chk("reset.busy", busy, 0);
      chk("reset.done", done, 0);
      chk("reset.tap_load", tap_load, 0);
      chk("reset.status", {locked, fail, eye_start, eye_width, phase_ofs, tap_value}, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle.busy", busy, 0);

      run_case("win8_19",   span(8, 19),                PAT,   0, 0, 8, 12, 14, 1, 0, 0, 0);
      run_case("two_win",   span(3, 5) | span(20, 27),  PAT,   0, 5, 20, 8, 24, 1, 0, 5, 1);
      run_case("equal_win", span(4, 7) | span(12, 15), PAT,   0, 7, 4, 4, 6, 1, 0, 7, 0);
      run_case("edge_win",  span(29, 31),               PAT,   0, 9, 29, 3, 30, 1, 0, 9, 0);
      run_case("all_bad",   32'h0,                      PAT,   0, 0, 0, 0, 0, 0, 1, 0, 0);
      run_case("narrow",    span(10, 11),               PAT,   0, 0, 10, 2, 0, 0, 1, 0, 0);
      run_case("phase3",    span(8, 19),                PAT,   0, 3, 8, 12, 14, 1, 0, 3, 0);
      run_case("no_align",  32'hffff_ffff,              OTHER, 0, 0, 0, 32, 16, 0, 1, 0, 0);
      run_case("stuck",     32'hffff_ffff,              PAT,   1, 0, 0, 0, 0, 0, 1, 0, 0);

      // Reset in the middle of the CHECK phase of tap 5.
      pass_mask = span(8, 19);
      word      = PAT;
      stuck     = 1'b0;
      load_cnt  = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < BUDGET && load_cnt < 6; i++) @(negedge clk);
      chk("rst_mid.reached_tap5", load_cnt, 6);
      repeat (30) @(negedge clk);
      chk("rst_mid.busy_before", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid.pat_en", pat_en, 0);
      chk("rst_mid.busy", busy, 0);
      chk("rst_mid.tap_load", tap_load, 0);
      chk("rst_mid.status", {done, locked, fail, eye_start, eye_width, phase_ofs, tap_value}, 0);
      rst = 1'b0;
      load_cnt = 0;
      repeat (100) @(negedge clk);
      chk("rst_mid.no_loads", load_cnt, 0);
      chk("rst_mid.idle", busy, 0);

      run_case("after_rst", span(8, 19), PAT, 0, 2, 8, 12, 14, 1, 0, 2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/dpa_train_ctrl.md
Name: dpa_train_ctrl

Overview:
- Receive-side training sequencer for the DPA link.
- Enables the transmit pattern generator, sweeps the input-delay tap across its full range, and qualifies each tap by checking that the received 2-bit DDR stream repeats with the 10-cycle pattern period.
- Picks the centre of the widest passing window, loads that tap, then reports the word-alignment offset against the known 20-bit pattern.
- Status feeds link-up logic.

Parameters:
- PATTERN, 20'b0000_0000_0011_1111_1111: training pattern; must match the transmitter.
- TAP_W, 5: delay tap width.
- NUM_TAPS, 32: taps swept, 0..NUM_TAPS-1. Must be <= 2^TAP_W.
- SETTLE_CYCLES, 16: wait after each tap load. Must be >= 10.
- CHECK_CYCLES, 64: compare cycles per tap.
- MIN_EYE, 3: minimum window width for lock.

Ports:
- clk  in  1  system clock, 125 MHz.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle training request; ignored unless in IDLE.
- pat_en  out  1  enable to the pattern generator.
- rx_data  in  2  received DDR bit pair, one pair per clk.
- tap_value  out  TAP_W  delay tap to apply.
- tap_load  out  1  one-cycle strobe; tap_value is valid in the same cycle.
- busy  out  1  training in progress.
- done  out  1  training finished (pass or fail); held until the next start.
- locked  out  1  eye found and alignment found.
- fail  out  1  eye too narrow or no alignment match.
- eye_start  out  TAP_W  first tap of the chosen window.
- eye_width  out  TAP_W+1  width of the chosen window.
- phase_ofs  out  4  alignment offset k, 0..9.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal run trackers 0.
- History register: hist[19:0] <= {hist[17:0], rx_data} every cycle, in all states. Period check compares rx_data against hist[19:18] (the pair from 10 cycles earlier).
- pat_en = 1 in every state except IDLE.
- busy = 1 in every state except IDLE.

State machine:
- IDLE: on start, clear done/locked/fail/eye_start/eye_width/phase_ofs, set tap = 0, go to LOAD.
- LOAD (1 cycle): drive tap_value = tap, pulse tap_load, go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to CHECK. The error flag and transition flag clear on entry to CHECK.
- CHECK: run CHECK_CYCLES cycles.
  - Error flag sets on any mismatch between rx_data and hist[19:18].
  - Transition flag sets if rx_data != hist[1:0].
  - Then go to EVAL.
- EVAL (1 cycle): pass = no error and transition seen.
  - On pass: if cur_len == 0, cur_start = tap; then cur_len += 1. If the new cur_len > best_len (strictly greater, so the first of equal windows wins), copy it to best_start/best_len.
  - On fail: cur_len = 0.
  - If tap == NUM_TAPS-1, go to CENTER; else tap += 1 and go to LOAD.
  - Windows do not wrap from the last tap to tap 0.
- CENTER (1 cycle): eye_start = best_start, eye_width = best_len.
  - If best_len < MIN_EYE: tap_value = 0, pulse tap_load, go to FINISH with fail.
  - Else: tap_value = best_start + floor(best_len/2), pulse tap_load, go to ALIGN_WAIT.
- ALIGN_WAIT: count SETTLE_CYCLES cycles, then go to ALIGN.
- ALIGN (1 cycle): find the smallest k in 0..9 with hist == ROTL20(PATTERN, 2k).
  - Match: phase_ofs = k, locked = 1.
  - No match: fail = 1, phase_ofs = 0.
  - Go to FINISH.
- FINISH (1 cycle): done = 1, go to IDLE. done, locked, fail and eye results hold in IDLE.

Timing and arithmetic:
- Per-tap latency is 2 + SETTLE_CYCLES + CHECK_CYCLES cycles. With defaults, a full sweep is 32 × 82 cycles.
- Counters saturate; nothing else wraps.
- tap_value holds its last loaded value outside LOAD/CENTER.

Boundary conditions:
- start while busy: ignored.
- start in the same cycle as FINISH: ignored; it is only accepted in IDLE.
- rst mid-operation: immediate return to reset values. pat_en drops the next cycle; no tap_load is issued.
- Constant rx_data (stuck line): passes the period check but fails the transition requirement, so the tap fails.

Test Plan:
- Loopback model passes taps 8..19 only, stream aligned so hist == PATTERN → tap_load final tap 14; eye_start 8, eye_width 12, phase_ofs 0, locked 1, done 1, fail 0.
- Two windows, 3..5 and 20..27 → eye_start 20, eye_width 8, final tap 24, locked 1.
- Equal windows, 4..7 and 12..15 → eye_start 4, final tap 6. Window at 29..31 → width 3, tap 30, locked (no wrap).
- Model corrupts every tap, or passes only 10..11 → fail 1, locked 0, final tap_value 0, done 1.
- Stream delayed so hist == ROTL20(PATTERN, 6) at ALIGN → phase_ofs 3. Random non-pattern periodic data at all taps → fail 1 after ALIGN.
- Second start during CHECK has no effect. rst asserted during CHECK of tap 5 → all outputs 0 next cycle, pat_en 0. A fresh start afterwards completes normally.
